hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipelined CPU.
- Sits beside the ID stage and drives the stall, bubble and forwarding controls that the current pipeline lacks.
- Tracks every in-flight register write in a DEPTH-entry shift scoreboard (EX, MEM, WB, ...).
- For each ID source operand it selects a forwarding stage, or requests a stall when the producer is a load whose data is not ready yet.

---
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside the ID stage: tracks in-flight register
// writes in a shift scoreboard and picks a forwarding stage per source operand,
// or requests a stall when a load producer is too young to forward.
module hazard_scoreboard #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned FW         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_we,
  input  logic                 id_load,
  input  logic [AW-1:0]        id_rd,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*FW-1:0]   fwd_sel,
  output logic [DEPTH-1:0]     busy_vec,
  output logic [15:0]          stall_cnt
);

  localparam int unsigned CW = 16;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_load;
  logic [AW-1:0]    ent_rd [DEPTH];

  logic [NSRC-1:0]  stall_req;
  logic [AW-1:0]    src_j;
  logic             hit;
  logic             ins_c;

  // ID instruction enters the scoreboard only if it really writes a register
  assign ins_c = id_valid & id_we & ~flush & ~stall &
                 ((id_rd != '0) || (ZERO_REG == 0));

  assign busy_vec = ent_valid;

  // Per source: youngest matching producer wins; young loads stall instead
  always_comb begin
    fwd_sel   = '0;
    stall_req = '0;
    src_j     = '0;
    hit       = 1'b0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      src_j = id_src[j*AW +: AW];
      hit   = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!hit && ent_valid[k] && (ent_rd[k] == src_j) && id_src_used[j] &&
            id_valid && ((src_j != '0) || (ZERO_REG == 0))) begin
          hit = 1'b1;
          if (ent_load[k] && (k < LOAD_READY)) begin
            stall_req[j] = 1'b1;
          end else begin
            fwd_sel[j*FW +: FW] = FW'(k + 1);
          end
        end
      end
    end
    stall = (|stall_req) & ~flush;
  end

  // Scoreboard shift: entry 0 takes the ID instruction or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_rd[k] <= '0;
      end
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_rd[k]    <= ent_rd[k-1];
      end
      ent_valid[0] <= ins_c;
      ent_load[0]  <= ins_c & id_load;
      ent_rd[0]    <= ins_c ? id_rd : '0;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed plan items plus random traffic checked
// against a cycle-history reference model; a second deep instance covers
// ZERO_REG=0 and stall counter saturation.
module tb_hazard_scoreboard;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned LR    = 1;
  localparam int unsigned FW    = 2;
  localparam int unsigned BD    = 16;
  localparam int unsigned BLR   = 15;
  localparam int unsigned BFW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A (default parameters)
  logic              a_valid, a_we, a_load, a_flush;
  logic [AW-1:0]     a_rd;
  logic [NSRC*AW-1:0] a_src;
  logic [NSRC-1:0]   a_used;
  logic              a_stall;
  logic [NSRC*FW-1:0] a_fwd;
  logic [DEPTH-1:0]  a_busy;
  logic [15:0]       a_cnt;

  // instance B (deep, late load forwarding, no hardwired zero)
  logic              b_valid, b_we, b_load, b_flush;
  logic [AW-1:0]     b_rd;
  logic [NSRC*AW-1:0] b_src;
  logic [NSRC-1:0]   b_used;
  logic              b_stall;
  logic [NSRC*BFW-1:0] b_fwd;
  logic [BD-1:0]     b_busy;
  logic [15:0]       b_cnt;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_READY(LR), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .id_valid(a_valid), .id_we(a_we), .id_load(a_load),
    .id_rd(a_rd), .id_src(a_src), .id_src_used(a_used), .flush(a_flush),
    .stall(a_stall), .fwd_sel(a_fwd), .busy_vec(a_busy), .stall_cnt(a_cnt));

  hazard_scoreboard #(.AW(AW), .DEPTH(BD), .NSRC(NSRC), .LOAD_READY(BLR), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(reset), .id_valid(b_valid), .id_we(b_we), .id_load(b_load),
    .id_rd(b_rd), .id_src(b_src), .id_src_used(b_used), .flush(b_flush),
    .stall(b_stall), .fwd_sel(b_fwd), .busy_vec(b_busy), .stall_cnt(b_cnt));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: one record per clock edge of what was written into the
  // pipeline; the producer k stages ahead of ID was inserted k+1 edges ago.
  typedef struct packed { logic v; logic [AW-1:0] rd; logic ld; } ent_t;
  ent_t        hist[$];
  int unsigned m_cnt = 0;
  bit          model_known = 1'b0;

  logic              obs_stall;
  logic [NSRC*FW-1:0] obs_fwd;
  logic [DEPTH-1:0]  obs_busy;
  logic [15:0]       obs_cnt;

  function automatic ent_t ent_at(input int k);
    int idx;
    idx = int'(hist.size()) - 1 - k;
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  task automatic cyc(input bit rst, input bit v, input bit we, input bit ld,
                     input bit [AW-1:0] rd, input bit [AW-1:0] s0, input bit [AW-1:0] s1,
                     input bit [1:0] used, input bit fl);
    logic              e_stall;
    logic [NSRC*FW-1:0] e_fwd;
    logic [DEPTH-1:0]  e_busy;
    logic              req;
    bit [AW-1:0]       s;
    ent_t              e;
    reset = rst; a_valid = v; a_we = we; a_load = ld; a_rd = rd;
    a_src = {s1, s0}; a_used = used; a_flush = fl;
    @(negedge clk);
    obs_stall = a_stall; obs_fwd = a_fwd; obs_busy = a_busy; obs_cnt = a_cnt;
    e_fwd = '0; req = 1'b0;
    for (int j = 0; j < int'(NSRC); j++) begin
      s = (j == 0) ? s0 : s1;
      for (int k = 0; k < int'(DEPTH); k++) begin
        e = ent_at(k);
        if (e.v && e.rd == s && used[j] && v && s != 0) begin
          if (e.ld && k < int'(LR)) req = 1'b1;
          else e_fwd[j*FW +: FW] = FW'(k + 1);
          break;
        end
      end
    end
    e_stall = req & ~fl;
    for (int k = 0; k < int'(DEPTH); k++) e_busy[k] = ent_at(k).v;
    if (model_known) begin
      check("m_stall", 32'(obs_stall), 32'(e_stall));
      check("m_fwd",   32'(obs_fwd),   32'(e_fwd));
      check("m_busy",  32'(obs_busy),  32'(e_busy));
      check("m_cnt",   32'(obs_cnt),   32'(m_cnt));
    end
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_cnt = 0;
      model_known = 1'b1;
    end else begin
      if (e_stall && m_cnt < 65535) m_cnt++;
      hist.push_back('{v: (v & we & ~fl & ~e_stall & (rd != 0)), rd: rd, ld: ld});
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  logic              bo_stall;
  logic [NSRC*BFW-1:0] bo_fwd;

  task automatic bcyc(input bit v, input bit we, input bit ld, input bit [AW-1:0] rd,
                      input bit [AW-1:0] s0, input bit [1:0] used);
    b_valid = v; b_we = we; b_load = ld; b_rd = rd; b_src = {AW'(0), s0}; b_used = used;
    @(negedge clk);
    bo_stall = b_stall; bo_fwd = b_fwd;
    @(posedge clk);
    #1;
  endtask

  task automatic bgroup();
    bcyc(1, 1, 1, 5'd1, 5'd0, 2'b00);
    for (int i = 0; i < int'(BLR); i++) bcyc(1, 0, 0, 5'd0, 5'd1, 2'b01);
  endtask

  initial begin
    b_valid = 0; b_we = 0; b_load = 0; b_rd = '0; b_src = '0; b_used = '0; b_flush = 0;

    // reset with random ID inputs
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
          AW'($urandom), 2'($urandom), 1'($urandom));
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("rst_busy",  32'(obs_busy),  32'd0);
    check("rst_cnt",   32'(obs_cnt),   32'd0);
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_fwd",   32'(obs_fwd),   32'd0);

    // ALU chain: forward from EX, MEM, WB, then register file
    cyc(0, 1, 1, 0, 5'd5, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 0, 0, 5'd5, 0, 2'b01, 0);
    check("alu_ex",    32'(obs_fwd[1:0]), 32'd1);
    check("alu_nostall", 32'(obs_stall),  32'd0);
    cyc(0, 1, 0, 0, 0, 5'd5, 0, 2'b01, 0);
    check("alu_mem",   32'(obs_fwd[1:0]), 32'd2);
    cyc(0, 1, 0, 0, 0, 5'd5, 0, 2'b01, 0);
    check("alu_wb",    32'(obs_fwd[1:0]), 32'd3);
    cyc(0, 1, 0, 0, 0, 5'd5, 0, 2'b01, 0);
    check("alu_rf",    32'(obs_fwd[1:0]), 32'd0);

    // load-use: one stall, then forward from MEM
    idle(3);
    cyc(0, 1, 1, 1, 5'd7, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 0, 0, 0, 5'd7, 2'b10, 0);
    check("ld_stall",  32'(obs_stall),    32'd1);
    check("ld_fwd0",   32'(obs_fwd[3:2]), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 5'd7, 2'b10, 0);
    check("ld_release", 32'(obs_stall),   32'd0);
    check("ld_fwd_mem", 32'(obs_fwd[3:2]), 32'd2);
    check("ld_cnt",    32'(obs_cnt),      32'd1);
    check("ld_bubble", 32'(obs_busy),     32'b010);

    // youngest producer wins
    idle(3);
    cyc(0, 1, 1, 0, 5'd3, 0, 0, 2'b00, 0);
    cyc(0, 1, 1, 0, 5'd3, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 0, 0, 5'd3, 0, 2'b01, 0);
    check("young_fwd", 32'(obs_fwd[1:0]), 32'd1);

    // zero register never tracked
    idle(3);
    cyc(0, 1, 1, 0, 5'd0, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 0, 0, 5'd0, 0, 2'b01, 0);
    check("zr_fwd",   32'(obs_fwd),   32'd0);
    check("zr_stall", 32'(obs_stall), 32'd0);
    check("zr_busy",  32'(obs_busy),  32'd0);

    // flush overrides stall and blocks insertion
    idle(3);
    cyc(0, 1, 1, 1, 5'd9, 0, 0, 2'b00, 0);
    cyc(0, 1, 1, 0, 5'd4, 5'd9, 0, 2'b01, 1);
    check("fl_stall", 32'(obs_stall), 32'd0);
    idle(1);
    check("fl_busy",  32'(obs_busy),  32'b010);

    // reset during a load-use stall
    idle(3);
    cyc(0, 1, 1, 1, 5'd6, 0, 0, 2'b00, 0);
    cyc(1, 1, 0, 0, 0, 5'd6, 0, 2'b01, 0);
    check("mr_stall_pre", 32'(obs_stall), 32'd1);
    idle(1);
    check("mr_stall", 32'(obs_stall), 32'd0);
    check("mr_busy",  32'(obs_busy),  32'd0);
    check("mr_cnt",   32'(obs_cnt),   32'd0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          AW'($urandom_range(0, 7)), 2'($urandom), ($urandom_range(0, 7) == 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // instance B: restart its counter from a clean reset
    reset = 1'b1;
    bcyc(0, 0, 0, 0, 0, 2'b00);
    reset = 1'b0;

    // register 0 is an ordinary register when not hardwired
    bcyc(1, 1, 0, 5'd0, 5'd0, 2'b00);
    bcyc(1, 0, 0, 5'd0, 5'd0, 2'b01);
    check("b_zr_fwd",   32'(bo_fwd[BFW-1:0]), 32'd1);
    check("b_zr_stall", 32'(bo_stall),        32'd0);

    // deep load: stalls until the producer reaches the last entry
    bcyc(1, 1, 1, 5'd1, 5'd0, 2'b00);
    for (int i = 0; i < int'(BLR); i++) begin
      bcyc(1, 0, 0, 5'd0, 5'd1, 2'b01);
      check("b_ld_stall", 32'(bo_stall), 32'd1);
    end
    bcyc(1, 0, 0, 5'd0, 5'd1, 2'b01);
    check("b_ld_release", 32'(bo_stall), 32'd0);
    check("b_ld_fwd",   32'(bo_fwd[BFW-1:0]), 32'd16);
    check("b_cnt15",    32'(b_cnt), 32'd15);

    // saturate: 4369 groups x 15 stalls = 65535, then more
    for (int g = 1; g < 4369; g++) bgroup();
    check("b_sat_reach", 32'(b_cnt), 32'd65535);
    bgroup();
    check("b_sat_stall", 32'(bo_stall), 32'd1);
    check("b_sat_hold",  32'(b_cnt), 32'd65535);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
